// File: rtl/vram_arbiter_if.sv
// Bundle of video-fetch, CPU-access and RAM-port signals around the VRAM arbiter.
// slave = arbiter view; master = requesters plus RAM (the surrounding SoC or a bench).
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  vidReq;
  logic [ADDR_WIDTH-1:0] vidAddr;
  logic [7:0]            vidData;
  logic                  vidValid;
  logic                  vidLate;
  logic                  cpuReq;
  logic                  cpuWe;
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [7:0]            cpuWData;
  logic [7:0]            cpuRData;
  logic                  cpuAck;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic                  ramWe;
  logic [7:0]            ramWData;
  logic [7:0]            ramRData;

  modport slave (
    input  vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    output vidData, vidValid, vidLate, cpuRData, cpuAck, ramAddr, ramWe, ramWData
  );

  modport master (
    output vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    input  vidData, vidValid, vidLate, cpuRData, cpuAck, ramAddr, ramWe, ramWData
  );
endinterface

// File: rtl/vram_arbiter.sv
// One access per cycle to a single-port VRAM: video fetch returns in 2 cycles (3 when delayed).
// CPU uses req/ack; once it has waited MAX_WAIT cycles it takes one slot and the video fetch is parked.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_WAIT   = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_READ, C_DONE} cpu_state_e;

  cpu_state_e            state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  vid_rd_q, vid_rd_d;
  logic [7:0]            vid_data_q, vid_data_d;
  logic                  vid_valid_q, vid_valid_d;
  logic                  vid_late_q, vid_late_d;
  logic [7:0]            cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;

  logic cpu_waiting, cpu_starved, grant_pend, grant_cpu, grant_vid, vid_defer;

  // Slot priority: pending video, starved CPU, new video, waiting CPU.
  always_comb begin
    cpu_waiting = (state_q == C_WAIT);
    cpu_starved = cpu_waiting && (wait_cnt_q == WAIT_LIMIT);
    grant_pend  = pend_vld_q;
    grant_cpu   = cpu_waiting && !pend_vld_q && (cpu_starved || !bus.vidReq);
    grant_vid   = bus.vidReq && !pend_vld_q && !cpu_starved;
    vid_defer   = bus.vidReq && !grant_vid;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_pend) begin
      ram_addr_d = pend_addr_q;
    end else if (grant_cpu) begin
      ram_addr_d = bus.cpuAddr;
      if (bus.cpuWe) ram_wdata_d = bus.cpuWData;
    end else if (grant_vid) begin
      ram_addr_d = bus.vidAddr;
    end

    // A request displaced in the same cycle the pending one is served simply reloads it.
    pend_vld_d  = vid_defer;
    pend_addr_d = vid_defer ? bus.vidAddr : pend_addr_q;
    vid_rd_d    = grant_pend || grant_vid;
    vid_valid_d = vid_rd_q;
    vid_data_d  = vid_rd_q ? bus.ramRData : vid_data_q;
    vid_late_d  = vid_late_q || vid_defer;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (bus.cpuReq) begin
          state_d    = C_WAIT;
          wait_cnt_d = '0;
        end
      end
      C_WAIT: begin
        if (grant_cpu) begin
          state_d   = bus.cpuWe ? C_DONE : C_READ;
          cpu_ack_d = bus.cpuWe;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      C_READ: begin
        cpu_rdata_d = bus.ramRData;
        cpu_ack_d   = 1'b1;
        state_d     = C_DONE;
      end
      C_DONE: begin
        // Held request is ignored until the requester drops it.
        if (!bus.cpuReq) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_IDLE;
      wait_cnt_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      vid_rd_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_late_q  <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      vid_rd_q    <= vid_rd_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      vid_late_q  <= vid_late_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.ramAddr  = reset ? '0 : ram_addr_d;
  assign bus.ramWData = reset ? '0 : ram_wdata_d;
  assign bus.ramWe    = !reset && grant_cpu && bus.cpuWe;
  assign bus.vidData  = vid_data_q;
  assign bus.vidValid = vid_valid_q;
  assign bus.vidLate  = vid_late_q;
  assign bus.cpuRData = cpu_rdata_q;
  assign bus.cpuAck   = cpu_ack_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of CPU/video vectors plus starvation, held-request and reset-abort sequences.
// Video and CPU completions are matched against expectation queues filled as stimulus is driven.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int MW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;
  int   ack_cnt = 0;
  int   wr_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  vram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [7:0] data; int cyc; } vid_exp_t;
  typedef struct { logic we; logic [7:0] rdata; int cyc; } cpu_exp_t;
  typedef struct { logic is_cpu; logic we; logic [AW-1:0] addr; logic [7:0] wdata; int lat; } vec_t;

  vid_exp_t   vq[$];
  cpu_exp_t   cq[$];
  vid_exp_t   ve;
  cpu_exp_t   ce;
  vec_t       vecs [9];
  logic [7:0] shadow  [0:(1<<AW)-1];
  logic [7:0] mem     [0:(1<<AW)-1];
  logic       written [0:(1<<AW)-1];

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    if (a == 13'h0040) return 8'hA5;
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  // Synchronous RAM: data for the address presented in cycle t appears in t+1.
  always @(posedge clk) begin
    if (bus.ramWe === 1'b1) begin
      mem[bus.ramAddr]     <= bus.ramWData;
      written[bus.ramAddr] <= 1'b1;
    end
    bus.ramRData <= (written[bus.ramAddr] === 1'b1) ? mem[bus.ramAddr] : init_val(bus.ramAddr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_push(input logic [AW-1:0] a, input int lat);
    bus.vidReq  = 1'b1;
    bus.vidAddr = a;
    vq.push_back('{shadow[a], cyc + lat});
  endtask

  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input int lat);
    bus.cpuReq   = 1'b1;
    bus.cpuWe    = we;
    bus.cpuAddr  = a;
    bus.cpuWData = d;
    cq.push_back('{we, shadow[a], cyc + lat});
    if (we) shadow[a] = d;
  endtask

  task automatic wait_ack(input int n0);
    int n = 0;
    while (ack_cnt == n0 && n < 30) begin
      step();
      n++;
    end
    check("ack_seen", ack_cnt - n0, 1);
  endtask

  always @(negedge clk) begin
    if (reset) check("ram_we_in_reset", 32'(bus.ramWe), 0);
    if (bus.ramWe === 1'b1 && !reset) wr_cnt++;
    if (bus.vidValid === 1'b1) begin
      if (vq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL vid_spurious: got vidValid=1 at cycle %0d, expected 0", cyc);
      end else begin
        ve = vq.pop_front();
        check("vid_cycle", cyc, ve.cyc);
        check("vid_data", 32'(bus.vidData), 32'(ve.data));
      end
    end
    if (bus.cpuAck === 1'b1) begin
      ack_cnt++;
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cpu_ack_spurious: got cpuAck=1 at cycle %0d, expected 0", cyc);
      end else begin
        ce = cq.pop_front();
        check("cpu_ack_cycle", cyc, ce.cyc);
        if (!ce.we) check("cpu_rdata", 32'(bus.cpuRData), 32'(ce.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int w0;
    bus.vidReq   = 1'b0;
    bus.vidAddr  = '0;
    bus.cpuReq   = 1'b0;
    bus.cpuWe    = 1'b0;
    bus.cpuAddr  = '0;
    bus.cpuWData = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(AW'(i));

    vecs[0] = '{1'b1, 1'b1, 13'h0123, 8'h5A, 2};
    vecs[1] = '{1'b1, 1'b0, 13'h0123, 8'h00, 3};
    vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 8'hC3, 2};
    vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 3};
    vecs[4] = '{1'b1, 1'b0, 13'h0000, 8'h00, 3};
    vecs[5] = '{1'b0, 1'b0, 13'h0040, 8'h00, 2};
    vecs[6] = '{1'b0, 1'b0, 13'h0123, 8'h00, 2};
    vecs[7] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 2};
    vecs[8] = '{1'b0, 1'b0, 13'h0ABC, 8'h00, 2};

    // Reset for 3 cycles with requests active.
    for (int i = 0; i < 3; i++) begin
      bus.cpuReq   = 1'b1;
      bus.cpuWe    = 1'b1;
      bus.cpuAddr  = 13'h0777;
      bus.cpuWData = 8'hEE;
      bus.vidReq   = (i != 1);
      bus.vidAddr  = 13'h0040;
      #1;
      check("ram_addr_in_reset", 32'(bus.ramAddr), 0);
      step();
    end
    reset      = 1'b0;
    bus.cpuReq = 1'b0;
    bus.vidReq = 1'b0;
    #1;
    check("rst_vid_valid", 32'(bus.vidValid), 0);
    check("rst_vid_late", 32'(bus.vidLate), 0);
    check("rst_cpu_ack", 32'(bus.cpuAck), 0);
    check("rst_vid_data", 32'(bus.vidData), 0);
    check("rst_cpu_rdata", 32'(bus.cpuRData), 0);
    check("rst_ram_we", 32'(bus.ramWe), 0);
    check("rst_ram_addr", 32'(bus.ramAddr), 0);
    check("rst_ram_wdata", 32'(bus.ramWData), 0);
    repeat (4) step();

    foreach (vecs[k]) begin
      if (vecs[k].is_cpu) begin
        n0 = ack_cnt;
        cpu_start(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].lat);
        step();
        #1;
        check("cpu_grant_we", 32'(bus.ramWe), 32'(vecs[k].we));
        check("cpu_grant_addr", 32'(bus.ramAddr), 32'(vecs[k].addr));
        if (vecs[k].we) check("cpu_grant_wdata", 32'(bus.ramWData), 32'(vecs[k].wdata));
        wait_ack(n0);
        bus.cpuReq = 1'b0;
        step();
      end else begin
        vid_push(vecs[k].addr, vecs[k].lat);
        #1;
        check("vid_grant_addr", 32'(bus.ramAddr), 32'(vecs[k].addr));
        check("vid_grant_we", 32'(bus.ramWe), 0);
        step();
        bus.vidReq = 1'b0;
        #1;
        check("idle_addr_hold", 32'(bus.ramAddr), 32'(vecs[k].addr));
        check("idle_we", 32'(bus.ramWe), 0);
        repeat (3) step();
      end
    end
    check("vid_late_clear", 32'(bus.vidLate), 0);

    // Video every cycle while a CPU read waits: CPU wins on its 9th wait cycle.
    n0 = ack_cnt;
    cpu_start(1'b0, 13'h0123, 8'h00, MW + 3);
    for (int i = 0; i < 16; i++) begin
      vid_push(13'h0100 + AW'(i), (i <= MW) ? 2 : 3);
      if (i == 12) bus.cpuReq = 1'b0;
      if (i == MW + 1) begin
        #1;
        check("starved_cpu_addr", 32'(bus.ramAddr), 'h123);
        check("starved_cpu_we", 32'(bus.ramWe), 0);
      end
      step();
    end
    bus.vidReq = 1'b0;
    repeat (5) step();
    check("starve_ack_count", ack_cnt - n0, 1);
    check("vid_late_set", 32'(bus.vidLate), 1);

    // Held request: exactly one access and one ack.
    n0 = ack_cnt;
    w0 = wr_cnt;
    cpu_start(1'b1, 13'h0200, 8'h77, 2);
    repeat (12) step();
    check("held_wr_count", wr_cnt - w0, 1);
    check("held_ack_count", ack_cnt - n0, 1);
    bus.cpuReq = 1'b0;
    step();
    n0 = ack_cnt;
    cpu_start(1'b0, 13'h0200, 8'h00, 3);
    wait_ack(n0);
    bus.cpuReq = 1'b0;
    step();

    // Reset the cycle after a read grant: the read must never be acknowledged.
    n0 = ack_cnt;
    bus.cpuReq  = 1'b1;
    bus.cpuWe   = 1'b0;
    bus.cpuAddr = 13'h0040;
    step();
    #1;
    check("abort_grant_addr", 32'(bus.ramAddr), 'h40);
    step();
    reset      = 1'b1;
    bus.cpuReq = 1'b0;
    step();
    reset = 1'b0;
    repeat (6) step();
    check("abort_no_ack", ack_cnt - n0, 0);
    check("vid_late_reset", 32'(bus.vidLate), 0);
    n0 = ack_cnt;
    cpu_start(1'b1, 13'h0300, 8'h3F, 2);
    step();
    #1;
    check("post_reset_grant_we", 32'(bus.ramWe), 1);
    wait_ack(n0);
    bus.cpuReq = 1'b0;
    repeat (3) step();

    check("vid_queue_empty", vq.size(), 0);
    check("cpu_queue_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port byte-wide video RAM between two requesters:
  - the video scan-out fetch path (VbsGenerator/VideoRAM side);
  - the CPU bus of the SoC.
- Video fetches have fixed latency and priority. CPU accesses use a req/ack handshake.
- A starvation guard bounds CPU wait time by delaying one video fetch a single cycle when needed.
- Runs entirely in the divided pixel clock domain (clkDiv at top level).

Parameters:
ADDR_WIDTH, 13, RAM address width in bytes (8 KiB).
MAX_WAIT, 8, CPU wait cycles after which the CPU beats a new video request (1..255).

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
vidReq  input  1  one-cycle pulse: fetch byte at vidAddr
vidAddr  input  ADDR_WIDTH  video fetch address, valid with vidReq
vidData  output  8  fetched byte, valid while vidValid=1
vidValid  output  1  one-cycle pulse, fetched data available
vidLate  output  1  sticky: at least one video fetch was delayed a cycle
cpuReq  input  1  CPU access request level; held with cpuWe/cpuAddr/cpuWData until cpuAck
cpuWe  input  1  1=write, 0=read
cpuAddr  input  ADDR_WIDTH  CPU address
cpuWData  input  8  CPU write data
cpuRData  output  8  CPU read data, valid with cpuAck on reads
cpuAck  output  1  one-cycle completion pulse
ramAddr  output  ADDR_WIDTH  RAM address (combinational from grant)
ramWe  output  1  RAM write enable (combinational from grant)
ramWData  output  8  RAM write data
ramRData  input  8  RAM read data; synchronous, valid the cycle after address

Behaviour:
- Reset:
  - vidValid, vidLate, cpuAck, ramWe = 0.
  - vidData, cpuRData, ramAddr, ramWData = 0.
  - Pending video register is emptied. CPU FSM goes to C_IDLE. Wait counter = 0.
  - In-flight accesses are discarded and no ack/valid is issued for them. ramWe is forced 0 during every reset cycle.
- Slot rule: exactly one RAM access per cycle. Priority, highest first:
  1. pending video;
  2. CPU whose wait counter has reached MAX_WAIT;
  3. new vidReq;
  4. CPU in C_WAIT.
- Idle slot: ramAddr holds its last value, ramWe=0.
- Video grant at cycle t:
  - ramAddr=vidAddr (or the pending address), ramWe=0.
  - vidData is registered from ramRData at t+1 and is visible with vidValid=1 in t+2.
  - Video latency is 2 cycles when served on request, 3 cycles when delayed.
- Video delay:
  - Occurs when vidReq collides with a higher-priority grant (pending video or starved CPU).
  - The request is stored in a one-deep pending register and served the next cycle. vidLate is set.
  - A new vidReq arriving while pending is being served reloads the pending register in the same cycle, so back-to-back requests stay one cycle late and none is dropped.
- CPU FSM states:
  - C_IDLE: on cpuReq -> C_WAIT, wait counter = 0.
  - C_WAIT: each cycle without a grant, the counter increments and saturates at MAX_WAIT.
    - Grant as a write: ramWe=1, ramAddr=cpuAddr, ramWData=cpuWData -> C_DONE, cpuAck=1 next cycle (t+1).
    - Grant as a read: -> C_READ.
  - C_READ: cpuRData is registered from ramRData at t+1, then -> C_DONE. cpuAck=1 at t+2.
  - C_DONE: cpuAck is a single pulse. Stay in C_DONE until cpuReq is sampled low, then -> C_IDLE. A held cpuReq never causes a second access.
- CPU wait bound: at most MAX_WAIT+1 cycles from entering C_WAIT to grant, regardless of video request rate.
- Simultaneous starved CPU and vidReq: the CPU wins, the video request goes to pending, and the pending request is served next cycle ahead of any CPU.
- vidLate is cleared only by reset.

Test Plan:
- Reset held 3 cycles, with cpuReq=1 and vidReq pulsing -> all outputs 0, ramWe=0 throughout, no cpuAck or vidValid after release until fresh requests are granted.
- CPU write 0x5A to 0x0123 with no video traffic -> ramWe=1 and ramAddr=0x0123 in cycle 1 after C_WAIT entry, cpuAck pulse next cycle. A subsequent read of 0x0123 returns cpuRData=0x5A with cpuAck 2 cycles after grant.
- vidReq at 0x0040 (RAM holds 0xA5) with CPU idle -> vidValid pulse exactly 2 cycles later, vidData=0xA5, vidLate stays 0.
- vidReq every cycle while cpuReq (read) is held -> CPU granted on cycle MAX_WAIT+1 (9 with defaults). The colliding video fetch returns at 3-cycle latency, vidLate=1, and every vidReq still produces exactly one vidValid, in order.
- cpuReq held high for 10 cycles after cpuAck -> only one RAM access and one cpuAck. After cpuReq drops for 1 cycle, a new request is accepted.
- Reset asserted the cycle after a CPU read grant -> no cpuAck is ever issued for that read, and the FSM is in C_IDLE after release.
